// File: rtl/uart_frame_pkg.sv
// Shared framing definitions for the UART TX/RX controllers:
// framing characters, parser states and size-code decoding.
package uart_frame_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_DATA = 4'b0010;
    localparam logic [3:0] ST_SEP  = 4'b0100;
    localparam logic [3:0] ST_LF   = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_DATA = ST_DATA,
        S_SEP  = ST_SEP,
        S_LF   = ST_LF
    } rx_state_t;

    // Unknown size codes fall back to a single-byte square.
    function automatic logic [7:0] code_to_width(input logic [7:0] code);
        case (code)
            8'h20:   return 8'd32;
            8'h80:   return 8'd128;
            8'hFF:   return 8'd255;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [15:0] code_to_total(input logic [7:0] code);
        case (code)
            8'h20:   return 16'd1024;
            8'h80:   return 16'd16384;
            8'hFF:   return 16'd65025;
            default: return 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle timer; expired stays high while the count sits at the limit.
module rx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] count;

    // A zero limit leaves the count parked at 0, so expiry never fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (run && count != LIMIT) begin
            count <= count + 32'd1;
        end
    end

    assign expired = (LIMIT != 32'd0) && (count == LIMIT);

endmodule

// File: rtl/uart_rx_parser.sv
// Parses the space/CR/LF framed byte stream from the UART receiver into
// data strobes, byte/row counters, error counts and a square-complete flag.
module uart_rx_parser
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [7:0]  num_of_bytes,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_frame_err,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        led,
    output logic [7:0]  total_row_count,
    output logic [15:0] byte_count,
    output logic [7:0]  err_count,
    output logic        timeout,
    output logic        finished
);

    rx_state_t   state;
    logic [7:0]  width;
    logic [15:0] total;
    logic [7:0]  row_count;
    logic        expired;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state != S_IDLE),
        .clear   (rx_valid || state == S_IDLE),
        .expired (expired)
    );

    // Mismatched separators still advance the state so the parser stays
    // aligned to byte positions rather than waiting for a matching char.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            width           <= 8'd0;
            total           <= 16'd0;
            row_count       <= 8'd0;
            data_out        <= 8'd0;
            data_valid      <= 1'b0;
            led             <= 1'b0;
            total_row_count <= 8'd0;
            byte_count      <= 16'd0;
            err_count       <= 8'd0;
            timeout         <= 1'b0;
            finished        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (arm) begin
                    width           <= code_to_width(num_of_bytes);
                    total           <= code_to_total(num_of_bytes);
                    byte_count      <= 16'd0;
                    row_count       <= 8'd0;
                    total_row_count <= 8'd0;
                    err_count       <= 8'd0;
                    timeout         <= 1'b0;
                    finished        <= 1'b0;
                    led             <= 1'b0;
                    state           <= S_DATA;
                end
            end else if (rx_valid) begin
                if (rx_frame_err) begin
                    err_count <= sat_inc(err_count);
                end else begin
                    case (state)
                        S_DATA: begin
                            data_out   <= rx_data;
                            data_valid <= 1'b1;
                            byte_count <= byte_count + 16'd1;
                            row_count  <= row_count + 8'd1;
                            led        <= ~led;
                            state      <= S_SEP;
                        end
                        S_SEP: begin
                            if (row_count == width) begin
                                if (rx_data != CH_CR) err_count <= sat_inc(err_count);
                                state <= S_LF;
                            end else begin
                                if (rx_data != CH_SPACE) err_count <= sat_inc(err_count);
                                state <= S_DATA;
                            end
                        end
                        S_LF: begin
                            if (rx_data != CH_LF) err_count <= sat_inc(err_count);
                            row_count       <= 8'd0;
                            total_row_count <= total_row_count + 8'd1;
                            if (byte_count == total) begin
                                finished <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (expired) begin
                timeout <= 1'b1;
                state   <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_parser.sv
// Self-checking bench for uart_rx_parser: directed framing cases plus
// randomized squares checked against a stream-level reference model.
module tb_uart_rx_parser;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [7:0]  num_of_bytes;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        led;
    logic [7:0]  total_row_count;
    logic [15:0] byte_count;
    logic [7:0]  err_count;
    logic        timeout;
    logic        finished;

    int tests_run = 0;
    int failures  = 0;
    int dv_count  = 0;

    uart_rx_parser #(
        .CLK_FREQ       (100_000_000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .arm             (arm),
        .num_of_bytes    (num_of_bytes),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_frame_err    (rx_frame_err),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .led             (led),
        .total_row_count (total_row_count),
        .byte_count      (byte_count),
        .err_count       (err_count),
        .timeout         (timeout),
        .finished        (finished)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) dv_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one byte for a single cycle; returns #1 after the sampling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic ferr);
        rx_valid     = 1'b1;
        rx_data      = b;
        rx_frame_err = ferr;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseArm(input logic [7:0] code);
        arm          = 1'b1;
        num_of_bytes = code;
        @(posedge clk);
        #1;
        arm          = 1'b0;
        num_of_bytes = $urandom;
    endtask

    task automatic doReset();
        reset = 1'b0;
        idleCycles(2);
        reset = 1'b1;
        idleCycles(1);
    endtask

    function automatic int modelWidth(input logic [7:0] code);
        if (code == 8'h20) return 32;
        if (code == 8'h80) return 128;
        if (code == 8'hFF) return 255;
        return 1;
    endfunction

    function automatic int modelTotal(input logic [7:0] code);
        return modelWidth(code) * modelWidth(code);
    endfunction

    // Sends whole rows; when corrupt is set, separators are sometimes replaced
    // and framing-error bytes injected, each counted as one expected error.
    task automatic sendRows(input int w, input int rows, input bit corrupt,
                            output int errs, output logic [7:0] last);
        logic [7:0] d;
        logic [7:0] sep;
        logic [7:0] bad;
        errs = 0;
        last = 8'h00;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                if (corrupt && $urandom_range(0, 15) == 0) begin
                    applyStimulus(8'($urandom), 1'b1);
                    errs++;
                end
                d = 8'($urandom);
                applyStimulus(d, 1'b0);
                last = d;
                sep = (c == w - 1) ? 8'h0D : 8'h20;
                if (corrupt && $urandom_range(0, 7) == 0) begin
                    bad = 8'($urandom);
                    if (bad == sep) bad = bad ^ 8'h01;
                    applyStimulus(bad, 1'b0);
                    errs++;
                end else begin
                    applyStimulus(sep, 1'b0);
                end
            end
            if (corrupt && $urandom_range(0, 7) == 0) begin
                applyStimulus(8'h55, 1'b0);
                errs++;
            end else begin
                applyStimulus(8'h0A, 1'b0);
            end
        end
    endtask

    initial begin
        int errs;
        int dv0;
        int w;
        int tot;
        int rows;
        int n;
        logic [7:0] last;
        logic [7:0] code;
        logic [7:0] codes [4];

        codes[0] = 8'h20; codes[1] = 8'h80; codes[2] = 8'hFF; codes[3] = 8'h05;
        reset = 1'b0; arm = 1'b0; num_of_bytes = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
        idleCycles(3);
        checkOutput("reset_data_out", 32'(data_out), 32'h0);
        checkOutput("reset_byte_count", 32'(byte_count), 32'h0);
        checkOutput("reset_flags", {28'h0, led, timeout, finished, data_valid}, 32'h0);
        reset = 1'b1;
        idleCycles(1);

        // Width-1 square
        dv0 = dv_count;
        pulseArm(8'h01);
        applyStimulus(8'h41, 1'b0);
        checkOutput("w1_data_valid", 32'(data_valid), 32'h1);
        checkOutput("w1_data_out", 32'(data_out), 32'h41);
        applyStimulus(8'h0D, 1'b0);
        applyStimulus(8'h0A, 1'b0);
        checkOutput("w1_dv_pulses", 32'(dv_count - dv0), 32'd1);
        checkOutput("w1_byte_count", 32'(byte_count), 32'd1);
        checkOutput("w1_rows", 32'(total_row_count), 32'd1);
        checkOutput("w1_finished", 32'(finished), 32'h1);
        checkOutput("w1_err", 32'(err_count), 32'h0);
        checkOutput("w1_led", 32'(led), 32'h1);

        // Bytes while idle are ignored
        dv0 = dv_count;
        applyStimulus(8'h77, 1'b0);
        applyStimulus(8'h20, 1'b1);
        idleCycles(1);
        checkOutput("idle_no_dv", 32'(dv_count - dv0), 32'd0);
        checkOutput("idle_byte_count", 32'(byte_count), 32'd1);
        checkOutput("idle_err", 32'(err_count), 32'h0);

        // Full width-32 square
        dv0 = dv_count;
        pulseArm(8'h20);
        sendRows(32, 32, 1'b0, errs, last);
        checkOutput("w32_byte_count", 32'(byte_count), 32'd1024);
        checkOutput("w32_rows", 32'(total_row_count), 32'd32);
        checkOutput("w32_finished", 32'(finished), 32'h1);
        checkOutput("w32_err", 32'(err_count), 32'h0);
        checkOutput("w32_dv_pulses", 32'(dv_count - dv0), 32'd1024);
        checkOutput("w32_data_out", 32'(data_out), 32'(last));

        // Separator error, framing error, arm while active
        pulseArm(8'h20);
        checkOutput("rearm_cleared", {7'h0, finished, total_row_count, byte_count}, 32'h0);
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'h2C, 1'b0);
        checkOutput("sep_err", 32'(err_count), 32'd1);
        applyStimulus(8'hB2, 1'b0);
        checkOutput("sep_resync_bc", 32'(byte_count), 32'd2);
        checkOutput("sep_resync_data", 32'(data_out), 32'hB2);
        applyStimulus(8'hC3, 1'b1);
        checkOutput("ferr_err", 32'(err_count), 32'd2);
        checkOutput("ferr_bc", 32'(byte_count), 32'd2);
        applyStimulus(8'h20, 1'b0);
        checkOutput("ferr_state_kept", 32'(err_count), 32'd2);
        pulseArm(8'h01);
        checkOutput("arm_active_bc", 32'(byte_count), 32'd2);
        checkOutput("arm_active_err", 32'(err_count), 32'd2);

        // Timeout after idle gap
        applyStimulus(8'hD4, 1'b0);
        checkOutput("arm_active_width", 32'(byte_count), 32'd3);
        idleCycles(TMO);
        checkOutput("tmo_not_yet", 32'(timeout), 32'h0);
        idleCycles(1);
        checkOutput("tmo_set", 32'(timeout), 32'h1);
        checkOutput("tmo_not_finished", 32'(finished), 32'h0);
        dv0 = dv_count;
        applyStimulus(8'h11, 1'b0);
        idleCycles(1);
        checkOutput("tmo_idle_no_dv", 32'(dv_count - dv0), 32'd0);

        // Byte arriving on the expiry cycle wins over the timeout
        pulseArm(8'h20);
        checkOutput("rearm_tmo_clr", 32'(timeout), 32'h0);
        applyStimulus(8'h01, 1'b0);
        idleCycles(TMO);
        applyStimulus(8'h20, 1'b0);
        checkOutput("expiry_byte_wins", 32'(timeout), 32'h0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("expiry_still_active", 32'(byte_count), 32'd2);
        checkOutput("expiry_err", 32'(err_count), 32'h0);

        // Reset mid-row
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h03, 1'b0);
        reset = 1'b0;
        #2;
        checkOutput("midrst_counts", {err_count, total_row_count, byte_count}, 32'h0);
        checkOutput("midrst_data", {15'h0, data_out, led, timeout, finished, data_valid}, 32'h0);
        idleCycles(1);
        reset = 1'b1;
        idleCycles(1);
        dv0 = dv_count;
        applyStimulus(8'h44, 1'b0);
        idleCycles(1);
        checkOutput("midrst_idle", 32'(dv_count - dv0), 32'd0);

        // Randomized squares against the stream-level model
        for (int it = 0; it < 4; it++) begin
            doReset();
            code = codes[$urandom_range(0, 3)];
            w    = modelWidth(code);
            tot  = modelTotal(code);
            rows = (tot == w) ? 1 : 2;
            n    = rows * w;
            dv0  = dv_count;
            pulseArm(code);
            sendRows(w, rows, 1'b1, errs, last);
            checkOutput("rnd_byte_count", 32'(byte_count), 32'(n));
            checkOutput("rnd_rows", 32'(total_row_count), 32'(rows));
            checkOutput("rnd_err", 32'(err_count), 32'(errs > 255 ? 255 : errs));
            checkOutput("rnd_finished", 32'(finished), 32'(n == tot));
            checkOutput("rnd_led", 32'(led), 32'(n % 2));
            checkOutput("rnd_data_out", 32'(data_out), 32'(last));
            checkOutput("rnd_dv_pulses", 32'(dv_count - dv0), 32'(n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
